// File: rtl/dds_phase_gen_if.sv
// Control/config/output bundle between the radar timing controller and the
// DDS phase generator. The controller side uses the master modport, the
// phase generator the slave modport.
interface dds_phase_gen_if #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
);

  // Controller -> phase generator
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [ACC_W-1:0] f_start;
  logic [ACC_W-1:0] f_step;
  logic [CNT_W-1:0] sweep_len;
  logic [CNT_W-1:0] gap_len;
  logic [7:0]       pulse_num;

  // Phase generator -> DDS core / controller
  logic [22:0]      rom_addr_reg;
  logic             phase_valid;
  logic             sweep_sync;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode, f_start, f_step, sweep_len, gap_len, pulse_num,
    input  rom_addr_reg, phase_valid, sweep_sync, busy, done
  );

  modport slave (
    input  start, stop, mode, f_start, f_step, sweep_len, gap_len, pulse_num,
    output rom_addr_reg, phase_valid, sweep_sync, busy, done
  );

endinterface

// File: rtl/dds_phase_gen.sv
// Phase-word source for the sine/cosine DDS lookup core.
// Produces CW, up-chirp, down-chirp and triangle LFM phase sequences as a
// registered 23-bit ROM address (top bits of an ACC_W-bit accumulator),
// with burst/pulse counting, inter-sweep gaps and start/stop/done handshake.
//
// Build option: define PHASE_DITHER_EN to add a 16-bit Galois LFSR dither
// below the truncation point (requires ACC_W > 23). Default build: plain
// truncation, no LFSR.
module dds_phase_gen #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic             sys_clk,
  input logic             sys_rst,
  dds_phase_gen_if.slave  bus
);

  localparam int unsigned AddrW = 23;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StSweep = 2'b01,
    StGap   = 2'b10
  } state_e;

  localparam logic [1:0] ModeCw   = 2'b00;
  localparam logic [1:0] ModeUp   = 2'b01;
  localparam logic [1:0] ModeDown = 2'b10;
  localparam logic [1:0] ModeTri  = 2'b11;

  // Control state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;      // remaining samples (SWEEP) or gap cycles (GAP)
  logic             first_q, first_d;  // next SWEEP cycle emits the first sample
  logic [7:0]       pcnt_q, pcnt_d;    // completed sweeps in this burst
  logic             dir_q, dir_d;      // triangle direction: 0 rising, 1 falling

  // Configuration captured when a burst is accepted
  logic [1:0]       mode_q, mode_d;
  logic [ACC_W-1:0] fstart_q, fstart_d;
  logic [ACC_W-1:0] fstep_q, fstep_d;
  logic [CNT_W-1:0] len_q, len_d;      // already forced to at least 1
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [7:0]       pnum_q, pnum_d;

  // Datapath
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [ACC_W-1:0] fcw_next;          // fcw after this cycle's chirp update
  logic [ACC_W-1:0] samp_acc;          // value presented to the truncation

  // Registered outputs
  logic [AddrW-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic [CNT_W-1:0] len_in_eff;
  logic [7:0]       pcnt_inc;

  assign accept     = (state_q == StIdle) && bus.start && !bus.stop;
  assign len_in_eff = (bus.sweep_len == '0) ? CNT_W'(1) : bus.sweep_len;
  assign pcnt_inc   = pcnt_q + 8'd1;

`ifdef PHASE_DITHER_EN
  localparam int unsigned DithW    = (ACC_W - AddrW > 16) ? 16 : (ACC_W - AddrW);
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LfsrMask = 16'hB400;

  logic [15:0] lfsr_q, lfsr_d;
  logic        advance;

  assign advance  = (state_q == StSweep) && !bus.stop;
  assign samp_acc = acc_q + ACC_W'(lfsr_q[DithW-1:0]);

  // LFSR next state: reseed on burst accept, step once per active sweep cycle
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = LfsrSeed;
    end else if (advance) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    end
  end

  // LFSR register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign samp_acc = acc_q;
`endif

  // Chirp-rate update applied on every active sweep cycle
  always_comb begin
    fcw_next = fcw_q;
    unique case (mode_q)
      ModeUp:   fcw_next = fcw_q + fstep_q;
      ModeDown: fcw_next = fcw_q - fstep_q;
      ModeTri:  fcw_next = dir_q ? (fcw_q - fstep_q) : (fcw_q + fstep_q);
      default:  fcw_next = fcw_q;
    endcase
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    pcnt_d   = pcnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstep_d  = fstep_q;
    len_d    = len_q;
    gap_d    = gap_q;
    pnum_d   = pnum_q;
    acc_d    = acc_q;
    fcw_d    = fcw_q;
    addr_d   = addr_q;
    valid_d  = 1'b0;
    sync_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mode_d   = bus.mode;
          fstart_d = bus.f_start;
          fstep_d  = bus.f_step;
          len_d    = len_in_eff;
          gap_d    = bus.gap_len;
          pnum_d   = bus.pulse_num;
          acc_d    = '0;
          fcw_d    = bus.f_start;
          cnt_d    = len_in_eff;
          first_d  = 1'b1;
          pcnt_d   = '0;
          dir_d    = 1'b0;
          state_d  = StSweep;
        end
      end

      StSweep: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          addr_d  = samp_acc[ACC_W-1 -: AddrW];
          valid_d = 1'b1;
          sync_d  = first_q;
          first_d = 1'b0;
          acc_d   = acc_q + fcw_q;
          fcw_d   = fcw_next;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // Last sample of this sweep
            pcnt_d = pcnt_inc;
            if ((pnum_q != 8'd0) && (pcnt_inc == pnum_q)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              // Chirps restart from f_start at phase 0; triangle reverses
              // slope but keeps phase and fcw continuous; CW just runs on.
              if ((mode_q == ModeUp) || (mode_q == ModeDown)) begin
                acc_d = '0;
                fcw_d = fstart_q;
              end
              if (mode_q == ModeTri) begin
                dir_d = ~dir_q;
              end
              if (gap_q != '0) begin
                state_d = StGap;
                cnt_d   = gap_q;
              end else begin
                cnt_d   = len_q;
                first_d = 1'b1;
              end
            end
          end
        end
      end

      StGap: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StSweep;
            cnt_d   = len_q;
            first_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // busy reflects the state being entered, so it drops the cycle IDLE returns
    busy_d = (state_d != StIdle);
  end

  // State, datapath and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      pcnt_q   <= '0;
      dir_q    <= 1'b0;
      mode_q   <= ModeCw;
      fstart_q <= '0;
      fstep_q  <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      pnum_q   <= '0;
      acc_q    <= '0;
      fcw_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      pcnt_q   <= pcnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      fstart_q <= fstart_d;
      fstep_q  <= fstep_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      pnum_q   <= pnum_d;
      acc_q    <= acc_d;
      fcw_q    <= fcw_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rom_addr_reg = addr_q;
  assign bus.phase_valid  = valid_q;
  assign bus.sweep_sync   = sync_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
